// File: rtl/johnson_pkg.sv
// johnson_pkg: FSM states, direction codes and Johnson-ring helpers shared by the sequencer.
package johnson_pkg;

    typedef enum logic [1:0] {IDLE, RUN, RECOVER} state_t;

    localparam logic FWD = 1'b0;
    localparam logic REV = 1'b1;
    localparam int MAXW = 32;

    // q arrives zero-extended to MAXW; w is the real ring width
    function automatic logic johnson_legal(input logic [MAXW-1:0] q, input int w);
        logic [MAXW:0] m, a, b;
        m = ((MAXW+1)'(1) << w) - (MAXW+1)'(1);
        a = {1'b0, q} & m;
        b = ~{1'b0, q} & m;
        return ((a & (a + (MAXW+1)'(1))) == '0) || ((b & (b + (MAXW+1)'(1))) == '0);
    endfunction

    function automatic int johnson_idx(input logic [MAXW-1:0] q, input int w);
        int pc;
        pc = 0;
        for (int i = 0; i < w; i++) pc += int'(q[i]);
        return q[w-1] ? 2 * w - pc : pc;
    endfunction

endpackage

// File: rtl/johnson_core.sv
// johnson_core: WIDTH-bit Johnson ring register with clear, load and bidirectional single step.
module johnson_core
    import johnson_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic             hz100,
    input  logic             reset_n,
    input  logic             step,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_nxt;

    assign q_nxt = clr  ? '0 :
                   load ? load_val :
                   step ? ((dir == FWD) ? {q[WIDTH-2:0], ~q[WIDTH-1]} : {~q[0], q[WIDTH-1:1]}) :
                   q;

    always_ff @(posedge hz100 or negedge reset_n)
        if (!reset_n)
            q <= '0;
        else
            q <= q_nxt;

endmodule

// File: rtl/johnson_sequencer.sv
// johnson_sequencer: button-driven controller for an 8-stage Johnson LED ring with
// single-step, free-run, index decode and illegal-pattern recovery.
module johnson_sequencer
    import johnson_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
)(
    input  logic                       hz100,
    input  logic                       reset_n,
    input  logic                       step_btn,
    input  logic                       run_btn,
    input  logic                       dir,
    input  logic [DIV_W-1:0]           rate,
    input  logic                       clr,
    input  logic                       load,
    input  logic [WIDTH-1:0]           load_val,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(2*WIDTH)-1:0] idx,
    output logic                       running,
    output logic                       fault
);

    localparam int IW = $clog2(2*WIDTH);

    logic [1:0]       step_sync, run_sync;
    logic             step_prev, run_prev, step_rise, run_rise;
    state_t           state, state_nxt, cur;
    logic [DIV_W-1:0] div, div_nxt, term;
    logic             step, recover, fault_nxt;

    always_ff @(posedge hz100 or negedge reset_n)
        if (!reset_n) begin
            step_sync <= '0;
            run_sync  <= '0;
            step_prev <= 1'b0;
            run_prev  <= 1'b0;
            state     <= IDLE;
            div       <= '0;
            fault     <= 1'b0;
        end else begin
            step_sync <= {step_sync[0], step_btn};
            run_sync  <= {run_sync[0], run_btn};
            step_prev <= step_sync[1];
            run_prev  <= run_sync[1];
            state     <= state_nxt;
            div       <= div_nxt;
            fault     <= fault_nxt;
        end

    assign step_rise = step_sync[1] & ~step_prev;
    assign run_rise  = run_sync[1] & ~run_prev;

    // an illegal ring overrides the stored state for the single recovery cycle
    assign cur     = johnson_legal(MAXW'(q), WIDTH) ? state : RECOVER;
    assign recover = (cur == RECOVER);
    assign term    = (rate == '0) ? '0 : rate - DIV_W'(1);

    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        step      = 1'b0;
        if (cur == RECOVER)
            state_nxt = IDLE;
        else if (cur == IDLE) begin
            step = step_rise;
            if (run_rise) begin
                state_nxt = RUN;
                div_nxt   = '0;
            end
        end else if (run_rise)
            state_nxt = IDLE;
        else if (div >= term) begin
            step    = 1'b1;
            div_nxt = '0;
        end else
            div_nxt = div + DIV_W'(1);
    end

    assign fault_nxt = recover ? 1'b1 : clr ? 1'b0 : fault;
    assign running   = (state == RUN);
    assign idx       = IW'(johnson_idx(MAXW'(q), WIDTH));

    johnson_core #(.WIDTH(WIDTH)) u_core (
        .hz100    (hz100),
        .reset_n  (reset_n),
        .step     (step & ~clr),
        .dir      (dir),
        .clr      (recover | clr),
        .load     (load),
        .load_val (load_val),
        .q        (q)
    );

endmodule

// File: tb/tb_johnson_sequencer.sv
// tb_johnson_sequencer: directed scoreboard bench for johnson_sequencer; the ring position
// is modelled as an index 0..15 and expanded to the expected LED pattern independently.
module tb_johnson_sequencer;

    logic       hz100 = 1'b0, reset_n = 1'b1, step_btn = 1'b0, run_btn = 1'b0;
    logic       dir = 1'b0, clr = 1'b0, load = 1'b0;
    logic [7:0] rate = 8'd0, load_val = 8'd0;
    logic [7:0] q;
    logic [3:0] idx;
    logic       running, fault;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic [3:0] idx;
        logic       run;
        logic       flt;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0, miscompares = 0;
    int         pos = 0;
    logic [7:0] qx = 8'd0;
    logic [3:0] ix = 4'd0;
    logic       runx = 1'b0, fltx = 1'b0;

    johnson_sequencer #(.WIDTH(8), .DIV_W(8)) dut (
        .hz100    (hz100),
        .reset_n  (reset_n),
        .step_btn (step_btn),
        .run_btn  (run_btn),
        .dir      (dir),
        .rate     (rate),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .idx      (idx),
        .running  (running),
        .fault    (fault)
    );

    always #5 hz100 = ~hz100;

    function automatic logic [7:0] pat(input int p);
        logic [7:0] ones;
        ones = 8'((16'd1 << (p % 8)) - 16'd1);
        return (p < 8) ? ones : ~ones;
    endfunction

    task automatic setpos(input int p);
        pos = p % 16;
        qx  = pat(pos);
        ix  = 4'(pos);
    endtask

    task automatic step_model();
        setpos(dir ? pos + 15 : pos + 1);
    endtask

    task automatic chk(input exp_t e);
        vectors++;
        assert ({q, idx, running, fault} === {e.q, e.idx, e.run, e.flt}) else begin
            miscompares++;
            $error("FAIL %s: got q=%h idx=%0d running=%b fault=%b, want q=%h idx=%0d running=%b fault=%b",
                   e.tag, q, idx, running, fault, e.q, e.idx, e.run, e.flt);
        end
    endtask

    task automatic now(input string tag);
        sb.push_back('{tag: tag, q: qx, idx: ix, run: runx, flt: fltx});
        chk(sb.pop_front());
    endtask

    task automatic cyc(input string tag);
        sb.push_back('{tag: tag, q: qx, idx: ix, run: runx, flt: fltx});
        @(posedge hz100);
        #1;
        chk(sb.pop_front());
    endtask

    task automatic press_step(input string tag);
        step_btn = 1'b1;
        cyc({tag, "_k"});
        step_btn = 1'b0;
        cyc({tag, "_k1"});
        step_model();
        cyc({tag, "_k2"});
    endtask

    task automatic press_run(input string tag);
        run_btn = 1'b1;
        cyc({tag, "_k"});
        run_btn = 1'b0;
        cyc({tag, "_k1"});
        runx = ~runx;
        cyc({tag, "_k2"});
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1 now("reset");
        repeat (2) @(posedge hz100);
        #1 reset_n = 1'b1;
        cyc("post_reset");

        step_btn = 1'b1;
        cyc("hold_k");
        cyc("hold_k1");
        step_model();
        cyc("hold_k2");
        cyc("hold_k3");
        step_btn = 1'b0;
        cyc("hold_rel");
        cyc("hold_rel2");
        press_step("fwd2");
        press_step("fwd3");
        for (int i = 0; i < 13; i++) press_step("fwd_wrap");

        dir = 1'b1;
        press_step("rev_wrap");
        dir = 1'b0;
        press_step("fwd_back");

        rate = 8'd4;
        press_run("run_on");
        for (int i = 0; i < 2; i++) begin
            repeat (3) cyc("rate4_wait");
            step_model();
            cyc("rate4_step");
        end
        rate = 8'd0;
        for (int i = 0; i < 4; i++) begin
            step_model();
            cyc("rate0_step");
        end
        rate = 8'd200;
        cyc("slow");
        press_run("run_off");
        repeat (3) cyc("stopped");

        press_run("run_on2");
        load = 1'b1;
        load_val = 8'h5A;
        qx = 8'h5A;
        ix = 4'd4;
        cyc("illegal_vis");
        load = 1'b0;
        setpos(0);
        runx = 1'b0;
        fltx = 1'b1;
        cyc("recover");
        cyc("fault_sticky");
        clr = 1'b1;
        fltx = 1'b0;
        cyc("clr_fault");
        clr = 1'b0;

        press_step("pre_clr");
        step_btn = 1'b1;
        cyc("coll_k");
        step_btn = 1'b0;
        cyc("coll_k1");
        clr = 1'b1;
        load = 1'b1;
        load_val = 8'h0F;
        setpos(0);
        cyc("clr_wins");
        clr = 1'b0;
        load = 1'b0;
        cyc("no_late_step");

        load = 1'b1;
        load_val = 8'h33;
        qx = 8'h33;
        ix = 4'd4;
        cyc("illegal2_vis");
        load = 1'b0;
        setpos(0);
        fltx = 1'b1;
        cyc("recover2");
        rate = 8'd2;
        press_run("run_on3");
        for (int i = 0; i < 2; i++) begin
            cyc("rate2_wait");
            step_model();
            cyc("rate2_step");
        end
        reset_n = 1'b0;
        setpos(0);
        runx = 1'b0;
        fltx = 1'b0;
        #1 now("async_reset");
        repeat (2) @(posedge hz100);
        @(negedge hz100);
        reset_n = 1'b1;
        cyc("after_release");
        press_step("alive");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/johnson_sequencer.md
# johnson_sequencer

Controller that owns and sequences an 8-stage Johnson ring for the lab board's LED bars. It turns raw push-button presses into single steps, free-runs at a programmable rate, and steps in either direction. It decodes the ring pattern into a 0..15 state index for the seven-segment display. It detects illegal ring patterns and recovers from them. It sits between the `pb` inputs and the `left`/`right` LED outputs in `top`.

## Interface
- `WIDTH`, default 8: Johnson stages; the ring has 2*WIDTH states.
- `DIV_W`, default 8: width of the run-rate divider.
- `hz100`, in, 1: system clock (100 Hz on board).
- `reset_n`, in, 1: asynchronous, active-low reset.
- `step_btn`, in, 1: raw button; each rising edge gives one step while in IDLE.
- `run_btn`, in, 1: raw button; each rising edge toggles between IDLE and RUN.
- `dir`, in, 1: level input. 0 = forward, 1 = reverse. Sampled at every step.
- `rate`, in, DIV_W: hz100 cycles per step in RUN. A value of 0 is treated as 1.
- `clr`, in, 1: synchronous level input. Forces `q` to 0 and clears `fault`.
- `load`, in, 1: synchronous level input. Writes `load_val` into `q`.
- `load_val`, in, WIDTH: pattern to load. Not checked at write time.
- `q`, out, WIDTH: Johnson ring pattern, drives the LED bar.
- `idx`, out, $clog2(2*WIDTH): decoded state index.
- `running`, out, 1: high while the FSM is in RUN.
- `fault`, out, 1: sticky flag, set when an illegal pattern is detected.

## Operation
- Reset (`reset_n` low, asynchronous) sets the following: `q`=0, `idx`=0, `running`=0, `fault`=0, FSM=IDLE, divider=0, and all synchronizer and edge registers to 0.
- Button handling:
  - `step_btn` and `run_btn` each pass through a 2-flop synchronizer and then a previous-value register.
  - A rising edge is detected as sync2 & ~prev.
  - There is no debounce beyond this; board buttons are already clean at 100 Hz.
- Forward step: `q` <= {q[W-2:0], ~q[W-1]}.
- Reverse step: `q` <= {~q[0], q[W-1:1]}.
- Index decode (combinational from `q`):
  - If q[W-1]=0, `idx` = popcount(q).
  - Otherwise, `idx` = 2W - popcount(q).
  - Examples: 0x00→0, 0x01→1, 0xFF→8, 0xFE→9, 0x80→15.
- Legal patterns are exactly the 2W Johnson codes (contiguous ones anchored at bit 0, or contiguous zeros anchored at bit 0). All other patterns are illegal.
- Update priority for `q`, highest first: RECOVER, `clr`, `load`, step. Only one step can occur per cycle.
- FSM states:
  - IDLE: a step_btn edge gives one step. A run_btn edge moves to RUN and sets the divider to 0.
  - RUN: the divider counts up each cycle. When it reaches max(rate,1)-1, it issues one step and returns to 0. A run_btn edge moves to IDLE. step_btn edges are ignored.
  - RECOVER: entered from IDLE or RUN whenever `q` is illegal. It lasts exactly one cycle and does three things: `q` <= 0, `fault` <= 1, next state = IDLE. Buttons, `load` and `clr` are ignored during RECOVER.
- `clr` asserted in any state other than RECOVER:
  - `q` <= 0 and `fault` <= 0.
  - The FSM state is kept.
  - Pending step edges in that cycle are dropped.
- `load`: `q` <= `load_val`. The legality check sees the new value on the following cycle.
- `rate` changes take effect at the divider's next comparison. If the divider is already ≥ the new terminal value, it steps immediately.

## Timing
- Button latency: take edge k as the first edge at which the raw input is sampled high. Its effect (step or mode change) appears in `q`/`running` after edge k+2. Holding the button gives one action only.
- RUN stepping:
  - The first step occurs max(rate,1) cycles after the edge that sets `running`.
  - After that, one step occurs every max(rate,1) cycles. `rate`=1 steps every cycle.
- Illegal load:
  - The illegal `q` is visible for exactly 1 cycle.
  - RECOVER occupies the next cycle.
  - `q`=0 and `fault`=1 appear 2 edges after `load` was sampled.
  - `running` drops in the same cycle that `fault` rises.
- Wrap-around:
  - 2W forward steps return `q` to its start value.
  - Forward from `idx` 15 goes to 0. Reverse from 0 goes to 15.
- `dir` may change at any time. A step uses the `dir` value sampled on that step's edge.
- Asserting `reset_n` mid-run sets all outputs to their reset values immediately (asynchronous). Release is synchronous to hz100.

## Structure
- Package `johnson_pkg` holds:
  - the FSM state enum: IDLE, RUN, RECOVER;
  - the direction constants FWD=0, REV=1;
  - the function johnson_legal(q);
  - the function johnson_idx(q).
- Sub-module `johnson_core` holds:
  - the WIDTH-bit ring register with asynchronous active-low reset;
  - inputs `step`, `dir`, `clr`, `load`, `load_val`.
- The top-level controller holds the synchronizers, edge detectors, divider, FSM and the fault flag.

## Test plan
- Reset, then 3 step_btn pulses with `dir`=0 → `q` = 0x01, 0x03, 0x07. Each change appears after edge k+2; `idx` = 1, 2, 3.
- Forward 16 steps from 0 → `q` passes through 0xFF (`idx` 8) and 0x80 (`idx` 15), then returns to 0x00. Reverse 1 step from 0x00 → 0x80, `idx` 15.
- run_btn pulse with `rate`=4 → `running`=1, and steps occur every 4 cycles. `rate`=0 → a step every cycle. Second run_btn pulse → `running`=0 and stepping stops.
- `load`=1 with `load_val`=0x5A → `q`=0x5A for 1 cycle, then `q`=0x00, `fault`=1, `running`=0. A later `clr` → `fault`=0.
- In IDLE, `clr` and `load` (0x0F) and a step edge all in the same cycle → `q`=0x00, no step.
- `reset_n` pulsed low mid-RUN → `q`=0, `running`=0, `fault`=0 within the same cycle.
